cmd_ram_param: RTL and testbench
================================

Name: cmd_ram_param

Overview:
- Parametrised command-decoded single-port RAM behind the SPI slave; next generation of the 8-bit/256-entry command RAM.
- Consumes framed words {opcode[1:0], payload} from the SPI slave on rx_valid and returns read data with tx_valid.
- Adds: generic data/address width, optional address auto-increment for burst transfers, a one-cycle tx_valid pulse, and an error flag for protocol violations.

Parameters:
- ADDR_WIDTH, 8, address bits; memory depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, memory word width; must be >= ADDR_WIDTH.
- AUTO_INC, 1, 1 = each data access increments its pointer modulo depth; 0 = pointers are static.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DATA_WIDTH+2  din[DATA_WIDTH+1:DATA_WIDTH] = opcode; din[DATA_WIDTH-1:0] = payload.
- rx_valid  in  1  din qualifier; one command per cycle while high.
- dout  out  DATA_WIDTH  read data.
- tx_valid  out  1  one-cycle pulse; dout is valid while high.
- err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (async assert, sync deassert): dout=0, tx_valid=0, err=0, wr_ptr=0, rd_ptr=0, wr_armed=0, rd_armed=0. Memory is not cleared; contents survive reset.
- Reset mid-burst: the burst aborts, both pointers clear, and both armed flags clear. The next data command errors until an address is reloaded.
- All decoding happens on the rising clk edge with rx_valid=1. rx_valid=0 means no state change; tx_valid and err return to 0.
- Opcode 00, WR_ADDR: wr_ptr <= payload[ADDR_WIDTH-1:0]; wr_armed <= 1. Upper payload bits are ignored.
- Opcode 01, WR_DATA:
  - If wr_armed: MEM[wr_ptr] <= payload. If AUTO_INC, wr_ptr <= wr_ptr+1, wrapping from 2**ADDR_WIDTH-1 to 0.
  - If not armed: no write; err pulses on the next cycle.
- Opcode 10, RD_ADDR: rd_ptr <= payload[ADDR_WIDTH-1:0]; rd_armed <= 1.
- Opcode 11, RD_DATA:
  - If rd_armed: dout <= MEM[rd_ptr] and tx_valid=1 for exactly one cycle. If AUTO_INC, rd_ptr increments with wrap-around.
  - If not armed: dout holds, tx_valid stays 0, err pulses.
- Latency: RD_DATA sampled at edge N gives dout and tx_valid visible after edge N (1-cycle latency). dout holds its value until the next successful RD_DATA.
- Back-to-back RD_DATA on consecutive cycles:
  - tx_valid stays high continuously.
  - dout updates every cycle with successive addresses (AUTO_INC=1) or the same address (AUTO_INC=0).
- Read-after-write to the same address:
  - WR_DATA at edge N, RD_DATA at edge N+1 returns the new data.
  - RD_DATA at edge N to an address being written at edge N returns the old data (read-before-write).
- Write and read pointers are independent; loading one never disturbs the other.
- tx_valid and err are never high together.
- State per command: IDLE -> ADDR_LOADED (armed) on address load -> stays armed through any number of data commands. Only reset disarms.

Test Plan:
- Reset then RD_DATA with no address loaded -> err=1 for one cycle, tx_valid=0, dout=0.
- WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> one cycle after RD_DATA: tx_valid=1, dout=0xA5; next idle cycle tx_valid=0, dout still 0xA5.
- AUTO_INC=1: WR_ADDR 0xFE, WR_DATA 0x11/0x22/0x33, then RD_ADDR 0xFE and three back-to-back RD_DATA -> dout 0x11, 0x22, 0x33 (addresses FE, FF, 00 wrap), tx_valid high for 3 consecutive cycles.
- AUTO_INC=0: WR_ADDR 0x05, WR_DATA 0x01 then 0x02, RD_ADDR 0x05, RD_DATA twice -> dout=0x02 both times.
- Async reset asserted mid-burst, between clock edges, after WR_ADDR 0x20 + WR_DATA 0x77 -> outputs 0 immediately. After release, WR_DATA 0x99 gives err=1. Then RD_ADDR 0x20 + RD_DATA gives dout=0x77 (memory retained).
- ADDR_WIDTH=4, DATA_WIDTH=12: WR_ADDR payload 0x3F7 (uses 0x7), WR_DATA 0xABC, RD_ADDR 0x007, RD_DATA -> dout=0xABC.

Source files
------------

// File: rtl/cmd_ram_param_if.sv
// cmd_ram_param_if: framed-command bus between the SPI slave and the command RAM
//   din      : {opcode[1:0], payload[DATA_WIDTH-1:0]} from the SPI slave
//   rx_valid : din qualifier, one command per cycle while high
//   dout     : read data back to the SPI slave
//   tx_valid : one-cycle pulse, dout valid while high
//   err      : one-cycle pulse on a protocol violation
interface cmd_ram_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH+1:0] din;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  err;

    modport master (output din, rx_valid, input dout, tx_valid, err);
    modport slave  (input din, rx_valid, output dout, tx_valid, err);
endinterface

// File: rtl/cmd_ram_param.sv
// cmd_ram_param: command-decoded single-port RAM with optional burst auto-increment
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (memory contents survive reset)
//   bus   : slave side of cmd_ram_param_if (din/rx_valid in, dout/tx_valid/err out)
module cmd_ram_param #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AUTO_INC   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    cmd_ram_param_if.slave     bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH < ADDR_WIDTH) begin : g_bad_width
        $error("cmd_ram_param: DATA_WIDTH must be >= ADDR_WIDTH");
    end

    typedef enum logic [1:0] {WR_ADDR, WR_DATA, RD_ADDR, RD_DATA} op_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    op_e                   op;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  wr_armed_q, wr_armed_d, rd_armed_q, rd_armed_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  tx_valid_q, tx_valid_d, err_q, err_d;
    logic                  we;

    assign op      = op_e'(bus.din[DATA_WIDTH+1:DATA_WIDTH]);
    assign payload = bus.din[DATA_WIDTH-1:0];
    // Pointer wrap modulo depth falls out of the ADDR_WIDTH-bit add
    assign step    = (AUTO_INC != 0) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_armed_d = wr_armed_q;
        rd_armed_d = rd_armed_q;
        dout_d     = dout_q;
        tx_valid_d = 1'b0;
        err_d      = 1'b0;
        we         = 1'b0;
        if (bus.rx_valid) begin
            case (op)
                WR_ADDR: begin
                    wr_ptr_d   = payload[ADDR_WIDTH-1:0];
                    wr_armed_d = 1'b1;
                end
                WR_DATA: begin
                    we       = wr_armed_q;
                    wr_ptr_d = wr_armed_q ? wr_ptr_q + step : wr_ptr_q;
                    err_d    = !wr_armed_q;
                end
                RD_ADDR: begin
                    rd_ptr_d   = payload[ADDR_WIDTH-1:0];
                    rd_armed_d = 1'b1;
                end
                RD_DATA: begin
                    // Reads the pre-edge array value, so a same-edge write is not seen
                    dout_d     = rd_armed_q ? mem[rd_ptr_q] : dout_q;
                    rd_ptr_d   = rd_armed_q ? rd_ptr_q + step : rd_ptr_q;
                    tx_valid_d = rd_armed_q;
                    err_d      = !rd_armed_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_armed_q <= 1'b0;
            rd_armed_q <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_armed_q <= wr_armed_d;
            rd_armed_q <= rd_armed_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    // No reset on the array: contents are retained across reset
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= payload;
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_cmd_ram_param.sv
// tb_cmd_ram_param: directed self-checking bench over three RAM configurations
module tb_cmd_ram_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cmd_ram_param_if #(.DATA_WIDTH(8))  b0 ();
    cmd_ram_param_if #(.DATA_WIDTH(8))  b1 ();
    cmd_ram_param_if #(.DATA_WIDTH(12)) b2 ();

    cmd_ram_param #(.ADDR_WIDTH(8), .DATA_WIDTH(8),  .AUTO_INC(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    cmd_ram_param #(.ADDR_WIDTH(8), .DATA_WIDTH(8),  .AUTO_INC(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    cmd_ram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(12), .AUTO_INC(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send0(input logic [1:0] op, input logic [7:0] pl);
        b0.din = {op, pl};
        b0.rx_valid = 1'b1;
        @(posedge clk);
        #1 b0.rx_valid = 1'b0;
    endtask

    task automatic send1(input logic [1:0] op, input logic [7:0] pl);
        b1.din = {op, pl};
        b1.rx_valid = 1'b1;
        @(posedge clk);
        #1 b1.rx_valid = 1'b0;
    endtask

    task automatic send2(input logic [1:0] op, input logic [11:0] pl);
        b2.din = {op, pl};
        b2.rx_valid = 1'b1;
        @(posedge clk);
        #1 b2.rx_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b0.din = '0; b0.rx_valid = 1'b0;
        b1.din = '0; b1.rx_valid = 1'b0;
        b2.din = '0; b2.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_dout", 32'(b0.dout), 32'h00);
        chk("rst_tx", 32'(b0.tx_valid), 32'h0);
        chk("rst_err", 32'(b0.err), 32'h0);

        send0(2'b11, 8'h00);
        chk("unarmed_rd_err", 32'(b0.err), 32'h1);
        chk("unarmed_rd_tx", 32'(b0.tx_valid), 32'h0);
        chk("unarmed_rd_dout", 32'(b0.dout), 32'h00);
        idle();
        chk("err_pulse_end", 32'(b0.err), 32'h0);

        send0(2'b00, 8'h10);
        send0(2'b01, 8'hA5);
        send0(2'b10, 8'h10);
        send0(2'b11, 8'h00);
        chk("basic_tx", 32'(b0.tx_valid), 32'h1);
        chk("basic_dout", 32'(b0.dout), 32'hA5);
        chk("basic_err", 32'(b0.err), 32'h0);
        idle();
        chk("basic_tx_drop", 32'(b0.tx_valid), 32'h0);
        chk("basic_dout_hold", 32'(b0.dout), 32'hA5);

        send0(2'b00, 8'hFE);
        send0(2'b01, 8'h11);
        send0(2'b01, 8'h22);
        send0(2'b01, 8'h33);
        send0(2'b10, 8'hFE);
        send0(2'b11, 8'h00);
        chk("burst_tx0", 32'(b0.tx_valid), 32'h1);
        chk("burst_d0", 32'(b0.dout), 32'h11);
        send0(2'b11, 8'h00);
        chk("burst_tx1", 32'(b0.tx_valid), 32'h1);
        chk("burst_d1", 32'(b0.dout), 32'h22);
        send0(2'b11, 8'h00);
        chk("burst_tx2", 32'(b0.tx_valid), 32'h1);
        chk("burst_d2_wrap", 32'(b0.dout), 32'h33);
        idle();
        chk("burst_tx_end", 32'(b0.tx_valid), 32'h0);

        send0(2'b00, 8'h50);
        send0(2'b10, 8'h50);
        send0(2'b01, 8'hC3);
        send0(2'b11, 8'h00);
        chk("raw_dout", 32'(b0.dout), 32'hC3);

        send1(2'b00, 8'h05);
        send1(2'b01, 8'h01);
        send1(2'b01, 8'h02);
        send1(2'b10, 8'h05);
        send1(2'b11, 8'h00);
        chk("static_d0", 32'(b1.dout), 32'h02);
        send1(2'b11, 8'h00);
        chk("static_tx1", 32'(b1.tx_valid), 32'h1);
        chk("static_d1", 32'(b1.dout), 32'h02);

        send0(2'b00, 8'h20);
        send0(2'b01, 8'h77);
        send0(2'b10, 8'h10);
        send0(2'b11, 8'h00);
        chk("pre_rst_dout", 32'(b0.dout), 32'hA5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(b0.dout), 32'h00);
        chk("async_rst_tx", 32'(b0.tx_valid), 32'h0);
        #1 rst_n = 1'b1;
        send0(2'b01, 8'h99);
        chk("post_rst_wr_err", 32'(b0.err), 32'h1);
        send0(2'b10, 8'h20);
        chk("post_rst_err_clear", 32'(b0.err), 32'h0);
        send0(2'b11, 8'h00);
        chk("retained_tx", 32'(b0.tx_valid), 32'h1);
        chk("retained_dout", 32'(b0.dout), 32'h77);

        send2(2'b00, 12'h3F7);
        send2(2'b01, 12'hABC);
        send2(2'b10, 12'h007);
        send2(2'b11, 12'h000);
        chk("narrow_dout", 32'(b2.dout), 32'hABC);
        send2(2'b00, 12'h00F);
        send2(2'b01, 12'h111);
        send2(2'b01, 12'h222);
        send2(2'b10, 12'h0F0);
        send2(2'b11, 12'h000);
        chk("narrow_wrap_dout", 32'(b2.dout), 32'h222);
        send2(2'b10, 12'h00F);
        send2(2'b11, 12'h000);
        chk("narrow_f_dout", 32'(b2.dout), 32'h111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
